// File: rtl/alu_result_accumulator.sv
// Frame-based saturating accumulator for adder/multiplier results.
// Collects FRAME samples via valid/ready, then holds the sum until downstream takes it.
module alu_result_accumulator #(
    parameter int ACC_W = 8,
    parameter int FRAME = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_in_op,
    input  logic [5:0]       i_in_result,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [ACC_W-1:0] o_out_acc,
    output logic [3:0]       o_out_count,
    output logic             o_out_sat
);

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(FRAME - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [ACC_W-1:0]   r_acc;
    logic [3:0]         r_count;
    logic               r_sat;

    logic               w_accept;
    logic               w_last;
    logic [5:0]         w_operand;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_sat_hit;

    // Adder results only carry 4 meaningful bits; upper bits may be garbage.
    assign w_operand  = i_in_op ? {2'b00, i_in_result[3:0]} : i_in_result;
    assign w_sum      = {1'b0, r_acc} + {{(ACC_W-5){1'b0}}, w_operand};
    assign w_sat_hit  = w_sum[ACC_W];
    assign w_acc_next = w_sat_hit ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

    assign o_in_ready = (r_state == S_ACCUM) && !i_clear;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_last     = (r_count == LAST_IDX);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_ACCUM: if (w_accept && w_last) w_next_state = S_HOLD;
            S_HOLD:  if (i_out_ready)        w_next_state = S_ACCUM;
            default:                         w_next_state = S_ACCUM;
        endcase
        if (i_clear) w_next_state = S_ACCUM;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_ACCUM;
            r_acc   <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (i_clear) begin
                r_acc   <= '0;
                r_count <= '0;
                r_sat   <= 1'b0;
            end else if (r_state == S_ACCUM) begin
                if (w_accept) begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + 4'd1;
                    r_sat   <= r_sat | w_sat_hit;
                end
            end else if (i_out_ready) begin
                r_acc   <= '0;
                r_count <= '0;
                r_sat   <= 1'b0;
            end
        end
    end

    assign o_out_valid = (r_state == S_HOLD);
    assign o_out_acc   = r_acc;
    assign o_out_count = r_count;
    assign o_out_sat   = r_sat;

endmodule
